// File: rtl/powlib_rrarb.sv
// powlib_rrarb -- round-robin arbiter feeding one valid/ready sink.
//
// N requesters compete for a single registered output stage. The search for
// a winner starts at a rotating pointer. With ELCK=1 a winner keeps the grant
// until it presents a last beat, so a whole burst is one turn. With ELCK=0
// every beat is treated as last.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   indata   N*W   requester data, requester i at [i*W +: W]
//   invld    N     per-requester valid
//   inrdy    N     per-requester ready (one-hot or zero)
//   inlst    N     per-requester last-beat flag
//   outdata  W     registered beat data
//   outlst   1     registered last flag
//   outidx   WIDX  registered source requester index
//   outvld   1     registered valid
//   outrdy   1     downstream ready
module powlib_rrarb #(
  parameter int    W    = 16,
  parameter int    N    = 4,
  parameter int    ELCK = 1,
  parameter string ID   = "RRARB",
  localparam int   WIDX = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  indata,
  input  logic [N-1:0]    invld,
  output logic [N-1:0]    inrdy,
  input  logic [N-1:0]    inlst,
  output logic [W-1:0]    outdata,
  output logic            outlst,
  output logic [WIDX-1:0] outidx,
  output logic            outvld,
  input  logic            outrdy
);

  if (N < 2) begin : g_badn
    $error("%s: N=%0d is invalid, at least 2 requesters are needed", ID, N);
  end

  typedef enum logic {IDLE, LOCKED} st_t;

  typedef struct packed {
    logic [W-1:0]    data;
    logic            lst;
    logic [WIDX-1:0] idx;
  } beat_t;

  st_t                 st, st_nxt;
  logic [WIDX-1:0]     ptr, ptr_nxt;
  logic [WIDX-1:0]     lckidx, lck_nxt;
  logic [WIDX-1:0]     sel;
  logic                selvld;
  logic                ld, acc, last;
  beat_t               obeat;
  logic [N-1:0][W-1:0] lane;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = indata[i*W +: W];
  end

  // Stage can take a beat when empty or when its current beat is leaving.
  assign ld = !outvld || outrdy;

  // Output logic: grant selection and ready generation.
  always_comb begin
    sel    = '0;
    selvld = 1'b0;
    if (st == LOCKED) begin
      sel    = lckidx;
      selvld = invld[lckidx];
    end else begin
      // Walk the rotation backwards so the candidate closest to ptr is the
      // final assignment and wins.
      for (int k = N-1; k >= 0; k--) begin
        if (invld[(int'(ptr) + k) % N]) begin
          sel    = WIDX'((int'(ptr) + k) % N);
          selvld = 1'b1;
        end
      end
    end
  end

  assign acc   = selvld && ld;
  assign last  = inlst[sel] || (ELCK == 0);
  assign inrdy = acc ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

  // Next-state logic: the pointer moves only at burst end.
  always_comb begin
    st_nxt  = st;
    ptr_nxt = ptr;
    lck_nxt = lckidx;
    if (acc) begin
      if (last) begin
        st_nxt  = IDLE;
        ptr_nxt = (sel == WIDX'(N-1)) ? '0 : sel + WIDX'(1);
      end else begin
        st_nxt  = LOCKED;
        lck_nxt = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      ptr    <= '0;
      lckidx <= '0;
    end else begin
      st     <= st_nxt;
      ptr    <= ptr_nxt;
      lckidx <= lck_nxt;
    end
  end

  // Output register: load on acceptance, drain when the sink takes the beat
  // and nothing replaces it, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obeat  <= '0;
      outvld <= 1'b0;
    end else if (acc) begin
      obeat  <= '{data: lane[sel], lst: inlst[sel], idx: sel};
      outvld <= 1'b1;
    end else if (outrdy) begin
      outvld <= 1'b0;
    end
  end

  assign outdata = obeat.data;
  assign outlst  = obeat.lst;
  assign outidx  = obeat.idx;

endmodule

// File: tb/tb_powlib_rrarb.sv
module tb_powlib_rrarb;
  localparam int N = 4;
  localparam int W = 16;
  localparam int WIDX = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] indata;
  logic [N-1:0]   invld, inlst;
  logic           outrdy;

  // r_* : ELCK=1 instance, z_* : ELCK=0 instance, same inputs.
  logic [N-1:0]    r_inrdy, z_inrdy;
  logic [W-1:0]    r_outdata, z_outdata;
  logic            r_outlst, z_outlst, r_outvld, z_outvld;
  logic [WIDX-1:0] r_outidx, z_outidx;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  powlib_rrarb #(.W(W), .N(N), .ELCK(1), .ID("RR1")) dut (
    .clk(clk), .rst(rst), .indata(indata), .invld(invld), .inrdy(r_inrdy),
    .inlst(inlst), .outdata(r_outdata), .outlst(r_outlst), .outidx(r_outidx),
    .outvld(r_outvld), .outrdy(outrdy));

  powlib_rrarb #(.W(W), .N(N), .ELCK(0), .ID("RR0")) dut0 (
    .clk(clk), .rst(rst), .indata(indata), .invld(invld), .inrdy(z_inrdy),
    .inlst(inlst), .outdata(z_outdata), .outlst(z_outlst), .outidx(z_outidx),
    .outvld(z_outvld), .outrdy(outrdy));

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0; invld = '0; inlst = '0; indata = '0; outrdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    indata[i*W +: W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; invld = '0; inlst = '0; indata = '0; outrdy = 1'b1;
    #3;
    checks++; if (r_outvld !== 1'b0) begin errs++; $display("FAIL reset_outvld got=%b exp=0", r_outvld); end
    checks++; if (r_outdata !== '0) begin errs++; $display("FAIL reset_outdata got=%h exp=0", r_outdata); end
    checks++; if (r_outidx !== '0) begin errs++; $display("FAIL reset_outidx got=%0d exp=0", r_outidx); end
    checks++; if (r_outlst !== 1'b0) begin errs++; $display("FAIL reset_outlst got=%b exp=0", r_outlst); end
    checks++; if (r_inrdy !== '0) begin errs++; $display("FAIL reset_inrdy got=%b exp=0", r_inrdy); end
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_rotation();
    int e;
    do_reset();
    invld = '1; inlst = '1;
    for (int i = 0; i < N; i++) set_data(i, 16'hA000 + 16'(i));
    for (int c = 0; c < 6; c++) begin
      e = c % N;
      #1;
      checks++; if (r_inrdy !== oh(e)) begin errs++; $display("FAIL rot_inrdy c=%0d got=%b exp=%b", c, r_inrdy, oh(e)); end
      @(posedge clk); #1;
      checks++; if (r_outidx !== WIDX'(e) || r_outvld !== 1'b1) begin errs++; $display("FAIL rot_outidx c=%0d got=%0d/%b exp=%0d/1", c, r_outidx, r_outvld, e); end
      checks++; if (r_outdata !== 16'hA000 + 16'(e)) begin errs++; $display("FAIL rot_outdata c=%0d got=%h exp=%h", c, r_outdata, 16'hA000 + 16'(e)); end
    end
  endtask

  task automatic test_burst();
    do_reset();
    set_data(0, 16'hB000); set_data(2, 16'hB200); set_data(3, 16'hB300);
    inlst = 4'b1001; invld = 4'b1101;
    #1;
    checks++; if (r_inrdy !== 4'b0001) begin errs++; $display("FAIL burst_first_inrdy got=%b exp=0001", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd0 || r_outdata !== 16'hB000) begin errs++; $display("FAIL burst_first_out got=%0d/%h exp=0/b000", r_outidx, r_outdata); end
    invld[0] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      inlst[2] = (b == 2);
      set_data(2, 16'hB200 + 16'(b));
      #1;
      checks++; if (r_inrdy !== 4'b0100) begin errs++; $display("FAIL burst_inrdy b=%0d got=%b exp=0100", b, r_inrdy); end
      @(posedge clk); #1;
      checks++; if (r_outidx !== 2'd2 || r_outdata !== 16'hB200 + 16'(b) || r_outlst !== (b == 2)) begin
        errs++; $display("FAIL burst_beat b=%0d got=%0d/%h/%b exp=2/%h/%b", b, r_outidx, r_outdata, r_outlst, 16'hB200 + 16'(b), (b == 2));
      end
    end
    invld[2] = 1'b0;
    #1;
    checks++; if (r_inrdy !== 4'b1000) begin errs++; $display("FAIL burst_next_inrdy got=%b exp=1000", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd3 || r_outdata !== 16'hB300) begin errs++; $display("FAIL burst_next_out got=%0d/%h exp=3/b300", r_outidx, r_outdata); end
  endtask

  task automatic test_lock_stall();
    do_reset();
    set_data(0, 16'hD000); set_data(1, 16'hD100);
    inlst = 4'b0001; invld = 4'b0010;
    #1;
    checks++; if (r_inrdy !== 4'b0010) begin errs++; $display("FAIL stall_lock_inrdy got=%b exp=0010", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd1 || r_outlst !== 1'b0) begin errs++; $display("FAIL stall_lock_out got=%0d/%b exp=1/0", r_outidx, r_outlst); end
    invld = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (r_inrdy !== 4'b0000) begin errs++; $display("FAIL stall_inrdy c=%0d got=%b exp=0000", c, r_inrdy); end
      @(posedge clk); #1;
      checks++; if (r_outvld !== 1'b0) begin errs++; $display("FAIL stall_outvld c=%0d got=%b exp=0", c, r_outvld); end
    end
    invld = 4'b0011; inlst = 4'b0011;
    #1;
    checks++; if (r_inrdy !== 4'b0010) begin errs++; $display("FAIL stall_release_inrdy got=%b exp=0010", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd1 || r_outlst !== 1'b1 || r_outdata !== 16'hD100) begin errs++; $display("FAIL stall_release_out got=%0d/%b/%h exp=1/1/d100", r_outidx, r_outlst, r_outdata); end
    invld = 4'b0001;
    #1;
    checks++; if (r_inrdy !== 4'b0001) begin errs++; $display("FAIL stall_after_inrdy got=%b exp=0001", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd0 || r_outdata !== 16'hD000) begin errs++; $display("FAIL stall_after_out got=%0d/%h exp=0/d000", r_outidx, r_outdata); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 16'hA000 + 16'(i));
    invld = '1; inlst = '1;
    #1;
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd0 || r_outvld !== 1'b1) begin errs++; $display("FAIL bp_first got=%0d/%b exp=0/1", r_outidx, r_outvld); end
    outrdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (r_inrdy !== 4'b0000) begin errs++; $display("FAIL bp_inrdy c=%0d got=%b exp=0000", c, r_inrdy); end
      @(posedge clk); #1;
      checks++; if (r_outdata !== 16'hA000 || r_outidx !== 2'd0 || r_outlst !== 1'b1 || r_outvld !== 1'b1) begin
        errs++; $display("FAIL bp_hold c=%0d got=%h/%0d/%b/%b exp=a000/0/1/1", c, r_outdata, r_outidx, r_outlst, r_outvld);
      end
    end
    outrdy = 1'b1;
    #1;
    checks++; if (r_inrdy !== 4'b0010) begin errs++; $display("FAIL bp_resume_inrdy got=%b exp=0010", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd1 || r_outdata !== 16'hA001) begin errs++; $display("FAIL bp_resume_out got=%0d/%h exp=1/a001", r_outidx, r_outdata); end
  endtask

  task automatic test_elck0();
    do_reset();
    set_data(0, 16'hE000); set_data(1, 16'hE001);
    invld = 4'b0011; inlst = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (z_inrdy !== oh(c % 2)) begin errs++; $display("FAIL elck0_inrdy c=%0d got=%b exp=%b", c, z_inrdy, oh(c % 2)); end
      @(posedge clk); #1;
      checks++; if (z_outidx !== WIDX'(c % 2) || z_outdata !== 16'hE000 + 16'(c % 2)) begin
        errs++; $display("FAIL elck0_out c=%0d got=%0d/%h exp=%0d", c, z_outidx, z_outdata, c % 2);
      end
      // The locking instance holds requester 0 for the whole non-last stream.
      checks++; if (r_outidx !== 2'd0) begin errs++; $display("FAIL elck1_lock c=%0d got=%0d exp=0", c, r_outidx); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_data(2, 16'hC200);
    invld = 4'b0100; inlst = 4'b0000;
    #1;
    @(posedge clk); #1;
    checks++; if (r_outvld !== 1'b1 || r_outidx !== 2'd2) begin errs++; $display("FAIL areset_pre got=%b/%0d exp=1/2", r_outvld, r_outidx); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (r_outvld !== 1'b0 || r_outidx !== 2'd0 || r_outdata !== '0) begin
      errs++; $display("FAIL areset_now got=%b/%0d/%h exp=0/0/0000", r_outvld, r_outidx, r_outdata);
    end
    invld = 4'b1010; inlst = 4'b1010;
    set_data(1, 16'hC100); set_data(3, 16'hC300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (r_inrdy !== 4'b0010) begin errs++; $display("FAIL areset_first_inrdy got=%b exp=0010", r_inrdy); end
    @(posedge clk); #1;
    checks++; if (r_outidx !== 2'd1 || r_outdata !== 16'hC100) begin errs++; $display("FAIL areset_first_out got=%0d/%h exp=1/c100", r_outidx, r_outdata); end
  endtask

  // Reference: rotation/lock rules applied directly to integer state.
  function automatic int mgrant(input bit lk, input int lck, input int p, input logic [N-1:0] v);
    if (lk) return v[lck] ? lck : -1;
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic test_random();
    bit             mlk[2];
    int             mlck[2], mptr[2], midx[2], g[2];
    logic           mvld[2], mlst[2], acc[2];
    logic [W-1:0]   mdata[2];
    logic [N-1:0]   ginrdy;
    logic [W-1:0]   gdata;
    logic [WIDX-1:0] gidx;
    logic           gvld, glst;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      mlk[m] = 0; mlck[m] = 0; mptr[m] = 0; midx[m] = 0; mvld[m] = 0; mlst[m] = 0; mdata[m] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      invld = N'($urandom);
      for (int i = 0; i < N; i++) begin
        inlst[i] = ($urandom_range(0, 1) == 1);
        set_data(i, W'($urandom));
      end
      outrdy = ($urandom_range(0, 3) != 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        g[m] = mgrant(mlk[m], mlck[m], mptr[m], invld);
        acc[m] = (g[m] >= 0) && (!mvld[m] || outrdy);
        ginrdy = (m == 0) ? r_inrdy : z_inrdy;
        checks++; if (ginrdy !== (acc[m] ? oh(g[m]) : '0)) begin
          errs++; $display("FAIL rnd_inrdy m=%0d c=%0d got=%b exp=%b", m, c, ginrdy, acc[m] ? oh(g[m]) : '0);
        end
      end
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) begin
          mvld[m] = 1; mdata[m] = indata[g[m]*W +: W]; mlst[m] = inlst[g[m]]; midx[m] = g[m];
          if (inlst[g[m]] || m == 1) begin mlk[m] = 0; mptr[m] = (g[m] + 1) % N; end
          else begin mlk[m] = 1; mlck[m] = g[m]; end
        end else if (outrdy) begin
          mvld[m] = 0;
        end
        gvld  = (m == 0) ? r_outvld  : z_outvld;
        gdata = (m == 0) ? r_outdata : z_outdata;
        gidx  = (m == 0) ? r_outidx  : z_outidx;
        glst  = (m == 0) ? r_outlst  : z_outlst;
        checks++; if (gvld !== mvld[m] || gdata !== mdata[m] || gidx !== WIDX'(midx[m]) || glst !== mlst[m]) begin
          errs++; $display("FAIL rnd_out m=%0d c=%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b",
                           m, c, gvld, gdata, gidx, glst, mvld[m], mdata[m], midx[m], mlst[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_burst();
    test_lock_stall();
    test_backpressure();
    test_elck0();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
